debounced_uart_io: RTL and testbench

- Board-level I/O front end with two independent sub-blocks sharing one clock and reset.
- Button debouncer: turns a raw, bouncy, asynchronous push-button into a single-cycle press pulse.
- UART transmitter: 8N1, valid/ready byte interface, serial line output.
- Sits between board pins and application FSMs, e.g. a press-to-print controller that sends a string one byte at a time.

---
 rtl/debounced_uart_io.sv | 159 +++++++++++++++
 tb/tb_debounced_uart_io.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounced_uart_io.sv
// debounced_uart_io: board-level I/O front end with two independent blocks
// that share one clock and one synchronous active-low reset.
//   - Push-button debouncer: turns a raw, bouncy, asynchronous button into a
//     single-cycle press pulse once the level has been stable long enough.
//   - 8N1 UART transmitter with a valid/ready byte interface.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active low
//   btn_raw      raw button, active high, asynchronous, may bounce
//   btn_pressed  one-cycle pulse per debounced press
//   data[7:0]    byte to transmit, captured when valid && ready
//   valid        transmit request
//   ready        high while the transmitter can take a byte
//   tx           serial line, idle high
module debounced_uart_io #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  output logic       btn_pressed,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CLKS_PER_BIT    = CLK_FREQ / BAUD;
  localparam int DEBOUNCE_CYCLES = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int DB_W            = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int BT_W            = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------
  // Debouncer: 2-flop synchroniser, then a run-length counter against the
  // current stable level. Any sample equal to the stable level restarts the
  // count, so only an uninterrupted run of DEBOUNCE_CYCLES changes state.
  // ---------------------------------------------------------------------
  logic            sync1;
  logic            sync2;
  logic            stable;
  logic [DB_W-1:0] db_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      stable      <= 1'b0;
      db_cnt      <= '0;
      btn_pressed <= 1'b0;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      btn_pressed <= 1'b0;
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable      <= sync2;
        db_cnt      <= '0;
        // only the 0->1 transition is reported; releases update silently
        btn_pressed <= sync2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // UART transmitter FSM
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [BT_W-1:0] bit_tmr;
  logic [2:0]      bit_idx;
  logic [2:0]      idx_nxt;
  logic [7:0]      shreg;
  logic            bit_done;
  logic            accept;
  logic            tx_nxt;

  assign bit_done = (bit_tmr == BT_LAST);
  assign accept   = valid && ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (valid)                        state_nxt = S_START;
      S_START: if (bit_done)                     state_nxt = S_DATA;
      S_DATA:  if (bit_done && bit_idx == 3'd7)  state_nxt = S_STOP;
      S_STOP:  if (bit_done)                     state_nxt = S_IDLE;
      default:                                   state_nxt = S_IDLE;
    endcase
  end

  // tx is computed from the upcoming state so the registered line changes
  // on the same edge as the state, with no combinational path to the pin.
  always_comb begin
    ready   = (state == S_IDLE);
    idx_nxt = bit_idx;
    if (state == S_IDLE) begin
      idx_nxt = 3'd0;
    end else if (state == S_DATA && bit_done) begin
      idx_nxt = bit_idx + 3'd1;
    end
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shreg[idx_nxt];
      default: tx_nxt = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // UART bit timing and line register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx      <= 1'b1;
      bit_tmr <= '0;
      bit_idx <= 3'd0;
    end else begin
      tx      <= tx_nxt;
      bit_idx <= idx_nxt;
      if (state == S_IDLE || bit_done) begin
        bit_tmr <= '0;
      end else begin
        bit_tmr <= bit_tmr + 1'b1;
      end
    end
  end

  // Byte holding register: only loaded on accept, so later changes on data
  // never reach a frame in flight.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= data;
    end
  end

endmodule

// File: tb/tb_debounced_uart_io.sv
module tb_debounced_uart_io;

  localparam int CLK_FREQ    = 1_000_000;
  localparam int BAUD        = 100_000;
  localparam int DEBOUNCE_MS = 1;
  localparam int CPB         = CLK_FREQ / BAUD;
  localparam int DEB         = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int FRAME       = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       btn_pressed;
  logic [7:0] data = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       tx;

  debounced_uart_io #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .DEBOUNCE_MS(DEBOUNCE_MS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_pressed(btn_pressed),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Edge counter and reset-at-edge flag, updated on every rising edge.
  int cyc = 0;
  bit rst_edge = 1'b0;

  // Button reference: a press is due two edges (synchroniser) after the
  // DEB-th consecutive raw sample that differs from the debounced level.
  bit m_stable = 1'b0;
  int m_run = 0;
  int pulse_q[$];

  always @(posedge clk) begin
    cyc++;
    rst_edge = !rst_n;
    if (!rst_n) begin
      m_stable = 1'b0;
      m_run    = 0;
      pulse_q.delete();
    end else if (btn_raw != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = btn_raw;
        m_run    = 0;
        if (m_stable) pulse_q.push_back(cyc + 2);
      end
    end else begin
      m_run = 0;
    end
  end

  // Press monitor
  int n_pulses = 0;
  int last_pulse = -1;

  always @(negedge clk) begin
    if (btn_pressed === 1'b1) begin
      n_pulses++;
      last_pulse = cyc;
      if (pulse_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_press: pulse at edge %0d, expected none", cyc);
      end else begin
        chk("press_edge", cyc, pulse_q.pop_front());
      end
    end
  end

  // UART scoreboard: stimulus pushes accepted bytes, this monitor watches
  // the line, pops on each start bit and checks all FRAME cycles.
  logic [7:0] byte_q[$];
  bit         fr_act = 1'b0;
  bit         fr_has = 1'b0;
  int         fr_i = 0;
  int         fr_bad = 0;
  logic [9:0] fr_exp = '1;
  logic [7:0] fr_b = 8'h00;
  logic [7:0] fr_dec = 8'h00;
  logic       prev_tx = 1'b1;
  int         last_start = -1;
  int         prev_start = -1;
  int         rlow = 0;

  always @(negedge clk) begin
    if (rst_edge) begin
      fr_act = 1'b0;
      rlow   = 0;
    end else begin
      if (!fr_act && prev_tx === 1'b1 && tx === 1'b0) begin
        fr_act     = 1'b1;
        fr_i       = 0;
        fr_bad     = 0;
        fr_dec     = 8'h00;
        prev_start = last_start;
        last_start = cyc;
        if (byte_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_frame: start bit at edge %0d, expected idle line", cyc);
          fr_has = 1'b0;
          fr_exp = 10'b1000000000;
        end else begin
          fr_b   = byte_q.pop_front();
          fr_exp = {1'b1, fr_b, 1'b0};
          fr_has = 1'b1;
        end
      end
      if (fr_act) begin
        if (tx !== fr_exp[fr_i / CPB]) fr_bad++;
        if ((fr_i % CPB) == CPB / 2 && fr_i / CPB >= 1 && fr_i / CPB <= 8)
          fr_dec[fr_i / CPB - 1] = tx;
        fr_i++;
        if (fr_i == FRAME) begin
          fr_act = 1'b0;
          if (fr_has) begin
            chk("frame_bad_cycles", fr_bad, 0);
            chk("frame_byte", fr_dec, fr_b);
          end
        end
      end
      if (ready === 1'b0) begin
        rlow++;
      end else begin
        if (rlow != 0) chk("ready_low_len", rlow, FRAME);
        rlow = 0;
      end
    end
    prev_tx = tx;
  end

  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget = 0;
    data   = b;
    valid  = 1'b1;
    while (ready !== 1'b1 && budget < 4 * FRAME) begin
      @(negedge clk);
      budget++;
    end
    if (ready !== 1'b1) begin
      checks++;
      $display("FAIL send_timeout: ready=%b, required 1 within %0d cycles", ready, 4 * FRAME);
    end else begin
      byte_q.push_back(b);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((ready !== 1'b1 || fr_act) && budget < 10 * FRAME) begin
      @(negedge clk);
      budget++;
    end
    if (ready !== 1'b1 || fr_act) begin
      checks++;
      $display("FAIL idle_timeout: ready=%b frame_active=%0d, required idle", ready, fr_act);
    end
    @(negedge clk);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

  logic [9:0] seen;
  int         first_hi;
  int         p0;
  int         hi_segs[4] = '{5, 37, 500, 999};

  initial begin
    seen = '0;
    rst_n = 1'b0;
    hold(3);
    chk("rst_tx", tx, 1);
    chk("rst_ready", ready, 1);
    chk("rst_press", btn_pressed, 0);
    rst_n = 1'b1;
    hold(1);
    chk("post_rst_tx", tx, 1);
    chk("post_rst_ready", ready, 1);

    // single byte, data scrambled while busy
    send_byte(8'h59);
    chk("ready_drop", ready, 0);
    valid = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      if ((k % CPB) == CPB / 2) seen[k / CPB] = tx;
      if (k == FRAME - 1) chk("ready_busy_end", ready, 0);
      data = 8'($urandom);
      @(negedge clk);
    end
    chk("ready_return", ready, 1);
    chk("frame_59", seen, 10'b1010110010);
    hold(1);

    // back-to-back with valid held and data changed mid-frame
    send_byte(8'h41);
    send_byte(8'h0A);
    valid = 1'b0;
    wait_idle();
    chk("b2b_start_gap", last_start - prev_start, FRAME + 1);

    // reset while a frame is on the line (data bit 2 of 0xC3 is 0 here)
    send_byte(8'hC3);
    valid = 1'b0;
    hold(37);
    rst_n = 1'b0;
    hold(1);
    chk("midrst_tx", tx, 1);
    chk("midrst_ready", ready, 1);
    rst_n = 1'b1;
    hold(1);
    chk("after_midrst_tx", tx, 1);
    chk("after_midrst_ready", ready, 1);

    // random bytes with random gaps
    for (int i = 0; i < 6; i++) begin
      send_byte(8'($urandom));
      valid = 1'b0;
      data  = 8'($urandom);
      hold(int'($urandom_range(0, 30)));
    end
    wait_idle();

    // clean press and release
    p0 = n_pulses;
    btn_raw = 1'b1;
    first_hi = cyc + 1;
    hold(2000);
    chk("clean_count", n_pulses - p0, 1);
    chk("clean_latency", last_pulse - first_hi, DEB + 1);
    p0 = n_pulses;
    btn_raw = 1'b0;
    hold(2000);
    chk("release_count", n_pulses - p0, 0);

    // bounce: every high segment shorter than DEB
    p0 = n_pulses;
    for (int s = 0; s < 4; s++) begin
      btn_raw = 1'b1;
      hold(hi_segs[s]);
      btn_raw = 1'b0;
      hold(3);
    end
    chk("bounce_none", n_pulses - p0, 0);
    btn_raw = 1'b1;
    first_hi = cyc + 1;
    hold(2000);
    chk("bounce_count", n_pulses - p0, 1);
    chk("bounce_latency", last_pulse - first_hi, DEB + 1);
    btn_raw = 1'b0;
    hold(2000);

    // reset part-way through a debounce restarts the count
    btn_raw = 1'b1;
    hold(600);
    rst_n = 1'b0;
    hold(1);
    rst_n = 1'b1;
    p0 = n_pulses;
    first_hi = cyc + 1;
    hold(2000);
    chk("rst_deb_count", n_pulses - p0, 1);
    chk("rst_deb_latency", last_pulse - first_hi, DEB + 1);
    btn_raw = 1'b0;
    hold(2000);

    // random button activity against the reference
    for (int i = 0; i < 10; i++) begin
      btn_raw = ~btn_raw;
      hold(int'($urandom_range(1, 1500)));
    end
    btn_raw = 1'b0;
    hold(2000);

    chk("press_queue_empty", pulse_q.size(), 0);
    chk("byte_queue_empty", byte_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
